// File: rtl/tge_txs_pkg.sv
// Shared sizes and state type for the 10GbE TX staging buffer playback path.
package tge_txs_pkg;

    localparam int unsigned TGE_TXS_AW = 13;
    localparam int unsigned TGE_TXS_DW = 128;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } tge_txs_state_e;

endpackage

// File: rtl/tge_txs_skid_fifo.sv
// Two-entry first-word-fall-through FIFO between the BRAM read port and the TX stream.
// When empty, an incoming word is presented on the head in the same cycle it arrives.
module tge_txs_skid_fifo
    import tge_txs_pkg::*;
#(
    parameter int unsigned DW = TGE_TXS_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    input  logic          flush,
    output logic [DW-1:0] head_data,
    output logic          head_valid,
    output logic [1:0]    count
);

    logic [DW-1:0] mem_q [2];
    logic          wr_ptr_q;
    logic          rd_ptr_q;
    logic [1:0]    count_q;
    logic          empty;
    logic          bypass;
    logic          do_write;
    logic          do_read;

    always_comb begin
        empty      = (count_q == 2'd0);
        head_valid = !empty || push;
        head_data  = '0;
        if (!empty) begin
            head_data = mem_q[rd_ptr_q];
        end else if (push) begin
            head_data = push_data;
        end
        // A word consumed on arrival into an empty FIFO never touches storage.
        bypass   = empty && push && pop;
        do_write = push && !bypass;
        do_read  = pop && !empty;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (flush) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_write) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_read) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, do_write} - {1'b0, do_read};
        end
    end

    assign count = count_q;

endmodule

// File: rtl/tge_txs_bram_playback.sv
// Drains the TX staging BRAM through port A and plays len words out as a valid/ready stream
// with end-of-frame marking on the last word.
module tge_txs_bram_playback
    import tge_txs_pkg::*;
#(
    parameter int unsigned AW     = TGE_TXS_AW,
    parameter int unsigned DW     = TGE_TXS_DW,
    parameter int unsigned RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW:0]   len,
    input  logic          abort,
    output logic          bram_en_a,
    output logic          bram_we,
    output logic [AW-1:0] bram_addr,
    output logic [DW-1:0] bram_wr_data,
    input  logic [DW-1:0] bram_rd_data,
    output logic [DW-1:0] tx_data,
    output logic          tx_valid,
    output logic          tx_eof,
    input  logic          tx_ready,
    output logic          busy,
    output logic          done
);

    localparam logic [AW:0] MaxLen = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] One    = {{AW{1'b0}}, 1'b1};

    tge_txs_state_e    state_q;
    tge_txs_state_e    state_d;
    logic [AW:0]       len_q;
    logic [AW:0]       issued_q;
    logic [AW:0]       sent_q;
    logic [AW:0]       len_clamped;
    logic [RD_LAT-1:0] inflight_q;
    logic [RD_LAT-1:0] inflight_d;
    int unsigned       pending;
    logic [1:0]        fifo_count;
    logic              fifo_valid;
    logic [DW-1:0]     fifo_data;
    logic              fifo_push;
    logic              fifo_pop;
    logic              start_ok;
    logic              issue;
    logic              last_word;

    always_comb begin
        start_ok    = start && !abort && (state_q == StIdle);
        len_clamped = (len > MaxLen) ? MaxLen : len;

        // Words already committed to the FIFO: stored ones plus reads still in the BRAM pipe.
        pending = 32'(fifo_count);
        for (int i = 0; i < RD_LAT; i++) begin
            pending = pending + 32'(inflight_q[i]);
        end

        issue = (state_q == StRun) && !abort && (issued_q < len_q) && (pending < 2);

        inflight_d    = '0;
        inflight_d[0] = issue;
        for (int i = 1; i < RD_LAT; i++) begin
            inflight_d[i] = inflight_q[i-1];
        end

        fifo_push = inflight_q[RD_LAT-1] && (state_q == StRun);
        fifo_pop  = fifo_valid && tx_ready && (state_q == StRun);
        last_word = ((sent_q + One) == len_q);

        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start_ok) begin
                    state_d = (len == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                if (fifo_pop && last_word) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (abort) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            len_q      <= '0;
            issued_q   <= '0;
            sent_q     <= '0;
            inflight_q <= '0;
        end else begin
            state_q    <= state_d;
            // Dropping the pipe bits discards read data still arriving after an abort.
            inflight_q <= abort ? '0 : inflight_d;
            if (start_ok) begin
                len_q    <= len_clamped;
                issued_q <= '0;
                sent_q   <= '0;
            end else begin
                if (issue) begin
                    issued_q <= issued_q + One;
                end
                if (fifo_pop) begin
                    sent_q <= sent_q + One;
                end
            end
        end
    end

    tge_txs_skid_fifo #(
        .DW (DW)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (fifo_push),
        .push_data  (bram_rd_data),
        .pop        (fifo_pop),
        .flush      (abort),
        .head_data  (fifo_data),
        .head_valid (fifo_valid),
        .count      (fifo_count)
    );

    assign bram_en_a    = issue;
    assign bram_we      = 1'b0;
    assign bram_addr    = issued_q[AW-1:0];
    assign bram_wr_data = '0;
    assign tx_data      = fifo_data;
    assign tx_valid     = fifo_valid;
    assign tx_eof       = fifo_valid && last_word;
    assign busy         = (state_q == StRun);
    assign done         = (state_q == StDone);

endmodule
